// File: rtl/stream_rx_fifo.sv
// ---------------------------------------------------------------------------
// stream_rx_fifo
//
// Receive buffer between a byte/word source (UART RX, JTAG shift capture) and
// the command decoder. Everything runs on one clock domain.
// - The read side is first-word-fall-through: the head word sits on out_data_o
//   while out_valid_o is high.
// - The write side either back-pressures the source through in_ready_o
//   (DROP_ON_FULL=0), or accepts every offered word and drops any that arrive
//   while the buffer is full (DROP_ON_FULL=1).
//
// Optional feature macro: RX_FIFO_STATS_EN
//   defined     -> drop_cnt_o (saturating) and high_water_o are implemented
//   not defined -> drop_cnt_o and high_water_o are tied to zero
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   flush_i        synchronous clear of contents
//   in_data_i      write data
//   in_valid_i     write request
//   in_ready_o     buffer can accept in_data_i (registered)
//   out_data_o     head word, meaningful when out_valid_o
//   out_valid_o    head word present
//   out_ready_i    consumer pops the head when out_valid_o && out_ready_i
//   count_o        words stored, including the head
//   free_o         DEPTH - count_o
//   almost_full_o  count_o >= AFULL_THRESH
//   overflow_o     sticky "a word was dropped" flag (DROP_ON_FULL=1 only)
//   clr_ovf_i      clears overflow_o; a same-cycle drop wins
//   drop_cnt_o     dropped-word counter
//   high_water_o   peak count since reset or flush
// ---------------------------------------------------------------------------
module stream_rx_fifo #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 256,
   parameter int ADDR_BITS    = $clog2(DEPTH),
   parameter int AFULL_THRESH = DEPTH - 4,
   parameter bit DROP_ON_FULL = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [WIDTH-1:0]     in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [WIDTH-1:0]     out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ADDR_BITS:0]   count_o,
   output logic [ADDR_BITS:0]   free_o,
   output logic                 almost_full_o,
   output logic                 overflow_o,
   input  logic                 clr_ovf_i,
   output logic [15:0]          drop_cnt_o,
   output logic [ADDR_BITS:0]   high_water_o
);

   localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0] AFULL_W = (ADDR_BITS+1)'(AFULL_THRESH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic [ADDR_BITS:0]   free_q, free_d;
   logic                 afull_q, afull_d;
   logic                 in_ready_q, in_ready_d;
   logic                 ovf_q, ovf_d;
   logic                 full, push, pop, drop;

   // Handshake decode. The FIFO is empty exactly when count is zero, so the
   // head is valid whenever anything is stored. In drop mode, a full buffer
   // still takes a word if the head leaves in the same cycle.
   always_comb begin
      full = (count_q == DEPTH_W);
      pop  = (count_q != '0) && out_ready_i;
      if (DROP_ON_FULL) begin
         push = in_valid_i && !(full && !pop);
         drop = in_valid_i && full && !pop;
      end else begin
         push = in_valid_i && in_ready_q;
         drop = 1'b0;
      end
   end

   // Next-state logic. Flush returns to the post-reset picture but keeps the
   // source side open and leaves the overflow history alone; a word offered
   // in the flush cycle simply vanishes.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      free_d     = free_q;
      afull_d    = afull_q;
      in_ready_d = in_ready_q;
      ovf_d      = ovf_q;
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         free_d     = DEPTH_W;
         afull_d    = 1'b0;
         in_ready_d = 1'b1;
         if (clr_ovf_i) ovf_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d    = count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
         free_d     = DEPTH_W - count_d;
         afull_d    = (count_d >= AFULL_W);
         in_ready_d = DROP_ON_FULL ? 1'b1 : (count_d < DEPTH_W);
         if (drop)           ovf_d = 1'b1;
         else if (clr_ovf_i) ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         free_q     <= DEPTH_W;
         afull_q    <= 1'b0;
         in_ready_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         free_q     <= free_d;
         afull_q    <= afull_d;
         in_ready_q <= in_ready_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage has no reset; stale words are never visible because the head
   // is masked whenever the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push) mem[wr_ptr_q] <= in_data_i;
   end

   assign out_valid_o   = (count_q != '0);
   assign out_data_o    = out_valid_o ? mem[rd_ptr_q] : '0;
   assign in_ready_o    = in_ready_q;
   assign count_o       = count_q;
   assign free_o        = free_q;
   assign almost_full_o = afull_q;
   assign overflow_o    = ovf_q;

`ifdef RX_FIFO_STATS_EN
   logic [15:0]        drop_cnt_q;
   logic [ADDR_BITS:0] high_water_q;

   // Drop counter survives flush and sticks at all-ones. The peak tracker
   // follows the same count value that the count register loads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_q   <= '0;
         high_water_q <= '0;
      end else if (flush_i) begin
         high_water_q <= '0;
      end else begin
         if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (count_d > high_water_q) high_water_q <= count_d;
      end
   end

   assign drop_cnt_o   = drop_cnt_q;
   assign high_water_o = high_water_q;
`else
   assign drop_cnt_o   = '0;
   assign high_water_o = '0;
`endif

endmodule

// File: tb/tb_stream_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_rx_fifo
//
// Drives two 8-deep, 8-bit instances of stream_rx_fifo from one clock:
//   d0 uses back-pressure (DROP_ON_FULL=0), d1 uses drop-on-full.
// Expected words are queued as they are handed to a DUT and are popped and
// compared as the DUT presents them at its head.
// ---------------------------------------------------------------------------
module tb_stream_rx_fifo;

   logic       clk;
   logic       rst;

   logic       flush0, in_valid0, out_ready0, clr_ovf0;
   logic [7:0] in_data0, out_data0;
   logic       in_ready0, out_valid0, af0, ovf0;
   logic [3:0] count0, free0, hw0;
   logic [15:0] dc0;

   logic       flush1, in_valid1, out_ready1, clr_ovf1;
   logic [7:0] in_data1, out_data1;
   logic       in_ready1, out_valid1, af1, ovf1;
   logic [3:0] count1, free1, hw1;
   logic [15:0] dc1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   stream_rx_fifo #(.WIDTH(8), .DEPTH(8), .DROP_ON_FULL(1'b0)) d0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush0),
      .in_data_i(in_data0), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
      .out_data_o(out_data0), .out_valid_o(out_valid0), .out_ready_i(out_ready0),
      .count_o(count0), .free_o(free0), .almost_full_o(af0),
      .overflow_o(ovf0), .clr_ovf_i(clr_ovf0),
      .drop_cnt_o(dc0), .high_water_o(hw0)
   );

   stream_rx_fifo #(.WIDTH(8), .DEPTH(8), .DROP_ON_FULL(1'b1)) d1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush1),
      .in_data_i(in_data1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
      .out_data_o(out_data1), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
      .count_o(count1), .free_o(free1), .almost_full_o(af1),
      .overflow_o(ovf1), .clr_ovf_i(clr_ovf1),
      .drop_cnt_o(dc1), .high_water_o(hw1)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached (got still running, want finished)");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready got=%b want=0", in_ready0); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid0); end
      checks++; if (out_data0 !== 8'h00) begin failures++; $display("[TB] FAIL rst_out_data got=%h want=00", out_data0); end
      checks++; if (count0 !== 4'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d want=0", count0); end
      checks++; if (free0 !== 4'd8) begin failures++; $display("[TB] FAIL rst_free got=%0d want=8", free0); end
      checks++; if (af0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_afull got=%b want=0", af0); end
      checks++; if (ovf1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_ovf got=%b want=0", ovf1); end
      checks++; if (dc1 !== 16'd0) begin failures++; $display("[TB] FAIL rst_drop_cnt got=%0d want=0", dc1); end
      checks++; if (hw0 !== 4'd0) begin failures++; $display("[TB] FAIL rst_high_water got=%0d want=0", hw0); end
      rst = 1'b0;
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_release_ready_early got=%b want=0", in_ready0); end
      tick();
      checks++; if (in_ready0 !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready0 got=%b want=1", in_ready0); end
      checks++; if (in_ready1 !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready1 got=%b want=1", in_ready1); end
   endtask

   // Mode 0: fill to full with out_ready low, offer a 9th word, then drain
   task automatic test_fill_drain();
      logic [7:0] exp;
      for (int i = 1; i <= 8; i++) begin
         in_valid0 = 1'b1;
         in_data0  = 8'(i);
         checks++; if (in_ready0 !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready[%0d] got=%b want=1", i, in_ready0); end
         q0.push_back(8'(i));
         tick();
         checks++; if (count0 !== 4'(i)) begin failures++; $display("[TB] FAIL fill_count[%0d] got=%0d want=%0d", i, count0, i); end
         checks++; if (af0 !== (i >= 4)) begin failures++; $display("[TB] FAIL fill_afull[%0d] got=%b want=%b", i, af0, (i >= 4)); end
      end
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b want=0", in_ready0); end
      checks++; if (free0 !== 4'd0) begin failures++; $display("[TB] FAIL full_free got=%0d want=0", free0); end
      in_data0 = 8'h99;
      tick();
      in_valid0 = 1'b0;
      checks++; if (count0 !== 4'd8) begin failures++; $display("[TB] FAIL ninth_word_count got=%0d want=8", count0); end
      `ifdef RX_FIFO_STATS_EN
      checks++; if (hw0 !== 4'd8) begin failures++; $display("[TB] FAIL high_water_full got=%0d want=8", hw0); end
      `endif
      out_ready0 = 1'b1;
      for (int k = 0; k < 20 && q0.size() > 0; k++) begin
         if (out_valid0 === 1'b1) begin
            exp = q0.pop_front();
            checks++; if (out_data0 !== exp) begin failures++; $display("[TB] FAIL drain_data got=%h want=%h", out_data0, exp); end
         end
         tick();
      end
      out_ready0 = 1'b0;
      checks++; if (q0.size() != 0) begin failures++; $display("[TB] FAIL drain_timeout got=%0d left want=0", q0.size()); end
      checks++; if (count0 !== 4'd0) begin failures++; $display("[TB] FAIL drain_count got=%0d want=0", count0); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL drain_valid got=%b want=0", out_valid0); end
      checks++; if (free0 !== 4'd8) begin failures++; $display("[TB] FAIL drain_free got=%0d want=8", free0); end
      q0.delete();
   endtask

   // First word falls through one cycle after it is written, and holds
   task automatic test_fwft();
      in_valid0 = 1'b1;
      in_data0  = 8'hA5;
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL fwft_pre_valid got=%b want=0", out_valid0); end
      tick();
      in_valid0 = 1'b0;
      checks++; if (out_valid0 !== 1'b1) begin failures++; $display("[TB] FAIL fwft_valid got=%b want=1", out_valid0); end
      checks++; if (out_data0 !== 8'hA5) begin failures++; $display("[TB] FAIL fwft_data got=%h want=a5", out_data0); end
      tick();
      checks++; if (out_data0 !== 8'hA5) begin failures++; $display("[TB] FAIL fwft_hold got=%h want=a5", out_data0); end
      out_ready0 = 1'b1;
      tick();
      out_ready0 = 1'b0;
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL fwft_popped got=%b want=0", out_valid0); end
   endtask

   // 20 words through the 8-deep buffer with a random consumer
   task automatic test_wrap();
      int sent = 0;
      logic [7:0] exp;
      for (int cyc = 0; cyc < 400 && (sent < 20 || q0.size() > 0); cyc++) begin
         out_ready0 = 1'($urandom_range(0, 1));
         in_valid0  = (sent < 20);
         in_data0   = 8'h40 + 8'(sent);
         if (in_valid0 && in_ready0) begin
            q0.push_back(in_data0);
            sent++;
         end
         if (out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL wrap_spurious got=%h want=no word", out_data0);
            end else begin
               exp = q0.pop_front();
               checks++; if (out_data0 !== exp) begin failures++; $display("[TB] FAIL wrap_data got=%h want=%h", out_data0, exp); end
            end
         end
         tick();
         checks++; if (count0 !== 4'(q0.size())) begin failures++; $display("[TB] FAIL wrap_count got=%0d want=%0d", count0, q0.size()); end
      end
      in_valid0  = 1'b0;
      out_ready0 = 1'b0;
      checks++; if (sent != 20 || q0.size() != 0) begin failures++; $display("[TB] FAIL wrap_timeout got=%0d sent/%0d left want=20/0", sent, q0.size()); end
      q0.delete();
   endtask

   // Mode 1: pass-through at full, drops, sticky overflow, clear
   task automatic test_drop_mode();
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) begin
         in_valid1 = 1'b1;
         in_data1  = 8'h10 + 8'(i);
         q1.push_back(in_data1);
         tick();
      end
      checks++; if (count1 !== 4'd8) begin failures++; $display("[TB] FAIL m1_fill_count got=%0d want=8", count1); end
      out_ready1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_data1 = 8'h20 + 8'(k);
         exp = q1.pop_front();
         checks++; if (out_data1 !== exp) begin failures++; $display("[TB] FAIL m1_pushpop_data got=%h want=%h", out_data1, exp); end
         q1.push_back(in_data1);
         tick();
         checks++; if (count1 !== 4'd8) begin failures++; $display("[TB] FAIL m1_pushpop_count got=%0d want=8", count1); end
         checks++; if (ovf1 !== 1'b0) begin failures++; $display("[TB] FAIL m1_pushpop_ovf got=%b want=0", ovf1); end
      end
      out_ready1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_data1 = 8'hE0 + 8'(k);
         tick();
      end
      checks++; if (ovf1 !== 1'b1) begin failures++; $display("[TB] FAIL m1_ovf_set got=%b want=1", ovf1); end
      checks++; if (count1 !== 4'd8) begin failures++; $display("[TB] FAIL m1_drop_count got=%0d want=8", count1); end
      checks++; if (in_ready1 !== 1'b1) begin failures++; $display("[TB] FAIL m1_ready got=%b want=1", in_ready1); end
      `ifdef RX_FIFO_STATS_EN
      checks++; if (dc1 !== 16'd3) begin failures++; $display("[TB] FAIL m1_drop_cnt got=%0d want=3", dc1); end
      `else
      checks++; if (dc1 !== 16'd0) begin failures++; $display("[TB] FAIL m1_drop_cnt got=%0d want=0", dc1); end
      `endif
      clr_ovf1 = 1'b1;
      in_data1 = 8'hEE;
      tick();
      checks++; if (ovf1 !== 1'b1) begin failures++; $display("[TB] FAIL m1_set_wins got=%b want=1", ovf1); end
      in_valid1 = 1'b0;
      tick();
      clr_ovf1 = 1'b0;
      checks++; if (ovf1 !== 1'b0) begin failures++; $display("[TB] FAIL m1_ovf_clear got=%b want=0", ovf1); end
      out_ready1 = 1'b1;
      for (int k = 0; k < 20 && q1.size() > 0; k++) begin
         if (out_valid1 === 1'b1) begin
            exp = q1.pop_front();
            checks++; if (out_data1 !== exp) begin failures++; $display("[TB] FAIL m1_drain_data got=%h want=%h", out_data1, exp); end
         end
         tick();
      end
      out_ready1 = 1'b0;
      checks++; if (q1.size() != 0 || count1 !== 4'd0) begin failures++; $display("[TB] FAIL m1_drain_end got=%0d count want=0", count1); end
      q1.delete();
   endtask

   // Flush at count 5 with a concurrent push
   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         in_valid0 = 1'b1;
         in_data0  = 8'h60 + 8'(i);
         tick();
      end
      checks++; if (count0 !== 4'd5) begin failures++; $display("[TB] FAIL flush_pre_count got=%0d want=5", count0); end
      flush0   = 1'b1;
      in_data0 = 8'h77;
      tick();
      flush0    = 1'b0;
      in_valid0 = 1'b0;
      checks++; if (count0 !== 4'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d want=0", count0); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b want=0", out_valid0); end
      checks++; if (free0 !== 4'd8) begin failures++; $display("[TB] FAIL flush_free got=%0d want=8", free0); end
      checks++; if (in_ready0 !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%b want=1", in_ready0); end
      checks++; if (af0 !== 1'b0) begin failures++; $display("[TB] FAIL flush_afull got=%b want=0", af0); end
      checks++; if (hw0 !== 4'd0) begin failures++; $display("[TB] FAIL flush_high_water got=%0d want=0", hw0); end
      in_valid0 = 1'b1;
      in_data0  = 8'h3C;
      tick();
      in_valid0 = 1'b0;
      checks++; if (out_data0 !== 8'h3C) begin failures++; $display("[TB] FAIL flush_next_word got=%h want=3c", out_data0); end
      `ifdef RX_FIFO_STATS_EN
      checks++; if (hw0 !== 4'd1) begin failures++; $display("[TB] FAIL flush_hw_restart got=%0d want=1", hw0); end
      `endif
      out_ready0 = 1'b1;
      tick();
      out_ready0 = 1'b0;
   endtask

   // Reset in the middle of traffic throws everything away
   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         in_valid0 = 1'b1;
         in_data0  = 8'h80 + 8'(i);
         tick();
      end
      rst        = 1'b1;
      out_ready0 = 1'b1;
      flush0     = 1'b1;
      tick();
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b want=0", out_valid0); end
      checks++; if (count0 !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_count got=%0d want=0", count0); end
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready got=%b want=0", in_ready0); end
      rst        = 1'b0;
      flush0     = 1'b0;
      in_valid0  = 1'b0;
      out_ready0 = 1'b0;
      tick();
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_glitch got=%b want=0", out_valid0); end
      checks++; if (in_ready0 !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready_back got=%b want=1", in_ready0); end
   endtask

   initial begin
      rst = 1'b1;
      flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; clr_ovf0 = 1'b0; in_data0 = 8'h00;
      flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; clr_ovf1 = 1'b0; in_data1 = 8'h00;
      test_reset();
      test_fill_drain();
      test_fwft();
      test_wrap();
      test_drop_mode();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
